memory_access: RTL and testbench
================================

MEMORY_ACCESS -- requirements
Module: memory_access

Interface
REQ-001 Parameter: DATA_WIDTH, 32, datapath width; only 32 is supported.
REQ-002 clk  input  1  pipeline clock; all state updates on the rising edge.
REQ-003 rst  input  1  reset; asynchronous, active-high.
REQ-004 RegWriteD, MemWriteD  input  1 each  control from the execute-stage output registers.
REQ-005 ResultSrcD  input  2  result select; 2'b01 means load.
REQ-006 PCPlus4D, ALUResultD, MemWriteDataD, UpperImmExtD  input  32 each  execute-stage data; ALUResultD is the byte address.
REQ-007 RdD  input  5  destination register; Funct3D  input  3  access size and sign.
REQ-008 dmem_req  output  1; dmem_we  output  1; dmem_addr  output  32; dmem_wdata  output  32; dmem_be  output  4  data-memory request.
REQ-009 dmem_ready  input  1; dmem_rdata  input  32  data-memory completion and read word.
REQ-010 StallM  output  1  stall request to the hazard unit; ForwardALUResultDH  output  32  equals ALUResultD, combinational.
REQ-011 RegWriteE  output  1; ResultSrcE  output  2; RdE  output  5; PCPlus4E, ALUResultE, ReadDataE, UpperImmExtE  output  32 each; MemFaultE  output  1  registered writeback-stage outputs.

Function
REQ-012 Memory op: MemWriteD=1 or ResultSrcD=2'b01; every other op is a pass-through.
REQ-013 FSM states: IDLE and WAIT.
- IDLE -> WAIT on a legal memory op with dmem_ready=0.
- WAIT -> IDLE on dmem_ready=1.
REQ-014 A pass-through op registers all D inputs to the E outputs in 1 cycle; ReadDataE=0; StallM=0.
REQ-015 Request signals are combinational:
- dmem_req=1 for a legal memory op in IDLE or WAIT.
- dmem_we=MemWriteD; dmem_addr={ALUResultD[31:2],2'b00}.
- dmem_req=0 for pass-through or faulting ops.
REQ-016 Same-cycle completion: dmem_ready=1 in the request cycle completes the access with 1-cycle latency and StallM=0.
REQ-017 Wait handling: StallM = dmem_req & ~dmem_ready.
- Upstream holds all D inputs stable while StallM=1.
- Each stalled cycle loads a bubble: RegWriteE=0, MemFaultE=0, other E outputs unchanged.
REQ-018 Store encoding:
- SB (000): dmem_be=4'b0001<<addr[1:0]; wdata = byte replicated x4.
- SH (001): be=0011 for addr[1]=0, 1100 for addr[1]=1; wdata = halfword replicated x2.
- SW (010): be=1111; wdata=MemWriteDataD.
REQ-019 Loads drive dmem_be=1111.
REQ-020 Load extraction at completion:
- Lane selected by ALUResultD[1:0].
- LB(000)/LH(001) sign-extend; LBU(100)/LHU(101) zero-extend; LW(010) passes the full word.
- Result registers into ReadDataE.
REQ-021 Fault: a memory op with any of the following is a fault:
- halfword with addr[0]=1;
- word with addr[1:0]!=0;
- Funct3D 011, 110 or 111;
- store Funct3D 1xx.
REQ-022 Fault response:
- No dmem request; no stall.
- Next cycle MemFaultE=1 for exactly 1 cycle with RegWriteE=0; other fields registered normally.
REQ-023 A memory-op completion registers RegWriteE=RegWriteD and ResultSrcE=ResultSrcD; a store forces RegWriteE=0.
REQ-024 dmem_addr, dmem_we, dmem_be and dmem_wdata stay constant while dmem_req=1 and dmem_ready=0.
REQ-025 dmem_ready while dmem_req=0 is ignored.

Reset
REQ-026 rst=1 forces, asynchronously:
- state=IDLE;
- all E outputs 0, including MemFaultE;
- dmem_req=0 and StallM=0 immediately.
REQ-027 Reset during WAIT abandons the access; no completion is reported after rst deasserts.
REQ-028 The first edge after rst deasserts accepts a new op normally.

Verification
REQ-029 Pass-through: ADD, ALUResultD=0x1234, RdD=5, RegWriteD=1 -> next edge RegWriteE=1, ALUResultE=0x1234, RdE=5, dmem_req=0 throughout.
REQ-030 SB: addr=0x103, data=0x000000A5, dmem_ready=1 -> dmem_be=1000, dmem_wdata=0xA5A5A5A5, RegWriteE=0.
REQ-031 LB: addr=0x202, rdata=0x00800000, 3 cycles of dmem_ready=0 then 1 -> StallM high 3 cycles, 3 bubbles, then ReadDataE=0xFFFFFF80; repeat with LBU -> ReadDataE=0x00000080.
REQ-032 LW: addr=0x302 -> dmem_req=0, StallM=0, next cycle MemFaultE=1, RegWriteE=0; MemFaultE=0 the following cycle.
REQ-033 LH in WAIT, rst pulsed -> dmem_req=0 immediately, all E outputs 0; a late dmem_ready is ignored.
REQ-034 SH: addr=0x2, data=0xBEEF -> dmem_be=1100, dmem_wdata=0xBEEFBEEF; completes in the same cycle.

Source files
------------

// File: rtl/memory_access.sv
// rtl/memory_access.sv - memory stage: data-memory requests, store lane packing, load extraction, E-stage registers
module memory_access #(
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  RegWriteD,
   input  logic                  MemWriteD,
   input  logic [1:0]            ResultSrcD,
   input  logic [DATA_WIDTH-1:0] PCPlus4D,
   input  logic [DATA_WIDTH-1:0] ALUResultD,
   input  logic [DATA_WIDTH-1:0] MemWriteDataD,
   input  logic [DATA_WIDTH-1:0] UpperImmExtD,
   input  logic [4:0]            RdD,
   input  logic [2:0]            Funct3D,
   output logic                  dmem_req,
   output logic                  dmem_we,
   output logic [DATA_WIDTH-1:0] dmem_addr,
   output logic [DATA_WIDTH-1:0] dmem_wdata,
   output logic [3:0]            dmem_be,
   input  logic                  dmem_ready,
   input  logic [DATA_WIDTH-1:0] dmem_rdata,
   output logic                  StallM,
   output logic [DATA_WIDTH-1:0] ForwardALUResultDH,
   output logic                  RegWriteE,
   output logic [1:0]            ResultSrcE,
   output logic [4:0]            RdE,
   output logic [DATA_WIDTH-1:0] PCPlus4E,
   output logic [DATA_WIDTH-1:0] ALUResultE,
   output logic [DATA_WIDTH-1:0] ReadDataE,
   output logic [DATA_WIDTH-1:0] UpperImmExtE,
   output logic                  MemFaultE
);

   typedef enum logic {IDLE = 1'b0, WAIT = 1'b1} state_t;

   state_t      state;
   logic        is_load;
   logic        mem_op;
   logic        bad_funct3;
   logic        misaligned;
   logic        fault;
   logic        legal;
   logic [1:0]  lane;
   logic [7:0]  ld_byte;
   logic [15:0] ld_half;
   logic [31:0] load_data;

   always_comb begin
      is_load    = (ResultSrcD == 2'b01);
      mem_op     = MemWriteD | is_load;
      lane       = ALUResultD[1:0];
      bad_funct3 = (Funct3D == 3'b011) | (Funct3D == 3'b110) | (Funct3D == 3'b111)
                 | (MemWriteD & Funct3D[2]);
      misaligned = 1'b0;
      if (Funct3D[1:0] == 2'b01)
         misaligned = lane[0];
      else if (Funct3D[1:0] == 2'b10)
         misaligned = (lane != 2'b00);
      fault = mem_op & (bad_funct3 | misaligned);
      legal = mem_op & ~fault;
   end

   // Gating with rst drops the request and stall in the same cycle reset rises
   assign dmem_req           = legal & ~rst;
   assign StallM             = dmem_req & ~dmem_ready;
   assign dmem_we            = MemWriteD;
   assign dmem_addr          = {ALUResultD[31:2], 2'b00};
   assign ForwardALUResultDH = ALUResultD;

   always_comb begin
      dmem_be    = 4'b1111;
      dmem_wdata = MemWriteDataD;
      if (MemWriteD) begin
         case (Funct3D[1:0])
            2'b00: begin
               dmem_be    = 4'b0001 << lane;
               dmem_wdata = {4{MemWriteDataD[7:0]}};
            end
            2'b01: begin
               dmem_be    = lane[1] ? 4'b1100 : 4'b0011;
               dmem_wdata = {2{MemWriteDataD[15:0]}};
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      ld_byte = dmem_rdata[{lane, 3'b000} +: 8];
      ld_half = lane[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
      case (Funct3D)
         3'b000:  load_data = {{24{ld_byte[7]}}, ld_byte};
         3'b001:  load_data = {{16{ld_half[15]}}, ld_half};
         3'b100:  load_data = {24'd0, ld_byte};
         3'b101:  load_data = {16'd0, ld_half};
         default: load_data = dmem_rdata;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= IDLE;
         RegWriteE    <= 1'b0;
         ResultSrcE   <= 2'b00;
         RdE          <= 5'd0;
         PCPlus4E     <= '0;
         ALUResultE   <= '0;
         ReadDataE    <= '0;
         UpperImmExtE <= '0;
         MemFaultE    <= 1'b0;
      end else begin
         case (state)
            IDLE: if (StallM) state <= WAIT;
            WAIT: if (dmem_ready || !dmem_req) state <= IDLE;
         endcase
         // A stalled cycle issues a bubble; data fields hold so forwarding stays stable
         if (StallM) begin
            RegWriteE <= 1'b0;
            MemFaultE <= 1'b0;
         end else begin
            RegWriteE    <= RegWriteD & ~MemWriteD & ~fault;
            ResultSrcE   <= ResultSrcD;
            RdE          <= RdD;
            PCPlus4E     <= PCPlus4D;
            ALUResultE   <= ALUResultD;
            ReadDataE    <= (legal & is_load) ? load_data : '0;
            UpperImmExtE <= UpperImmExtD;
            MemFaultE    <= fault;
         end
      end
   end

endmodule

// File: tb/tb_memory_access.sv
// tb/tb_memory_access.sv - randomized and directed self-checking bench for memory_access
`timescale 1ns/1ps
module tb_memory_access;

   logic        clk = 1'b0;
   logic        rst;
   logic        RegWriteD, MemWriteD;
   logic [1:0]  ResultSrcD;
   logic [31:0] PCPlus4D, ALUResultD, MemWriteDataD, UpperImmExtD;
   logic [4:0]  RdD;
   logic [2:0]  Funct3D;
   logic        dmem_req, dmem_we;
   logic [31:0] dmem_addr, dmem_wdata;
   logic [3:0]  dmem_be;
   logic        dmem_ready;
   logic [31:0] dmem_rdata;
   logic        StallM;
   logic [31:0] ForwardALUResultDH;
   logic        RegWriteE;
   logic [1:0]  ResultSrcE;
   logic [4:0]  RdE;
   logic [31:0] PCPlus4E, ALUResultE, ReadDataE, UpperImmExtE;
   logic        MemFaultE;

   int checks = 0;
   int failures = 0;
   bit cmp_en = 1'b0;

   always #5 clk = ~clk;

   memory_access #(.DATA_WIDTH(32)) dut (
      .clk(clk), .rst(rst),
      .RegWriteD(RegWriteD), .MemWriteD(MemWriteD), .ResultSrcD(ResultSrcD),
      .PCPlus4D(PCPlus4D), .ALUResultD(ALUResultD), .MemWriteDataD(MemWriteDataD),
      .UpperImmExtD(UpperImmExtD), .RdD(RdD), .Funct3D(Funct3D),
      .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
      .dmem_wdata(dmem_wdata), .dmem_be(dmem_be),
      .dmem_ready(dmem_ready), .dmem_rdata(dmem_rdata),
      .StallM(StallM), .ForwardALUResultDH(ForwardALUResultDH),
      .RegWriteE(RegWriteE), .ResultSrcE(ResultSrcE), .RdE(RdE),
      .PCPlus4E(PCPlus4E), .ALUResultE(ALUResultE), .ReadDataE(ReadDataE),
      .UpperImmExtE(UpperImmExtE), .MemFaultE(MemFaultE)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   function automatic bit f_memop(input logic mw, input logic [1:0] rs);
      return mw || (rs == 2'd1);
   endfunction

   function automatic bit f_fault(input logic mw, input logic [1:0] rs, input logic [2:0] f3,
                                  input logic [31:0] a);
      int size;
      size = f3 % 4;
      if (!f_memop(mw, rs)) return 1'b0;
      if (f3 == 3 || f3 == 6 || f3 == 7) return 1'b1;
      if (mw && f3 >= 4) return 1'b1;
      if ((a % (1 << size)) != 0) return 1'b1;
      return 1'b0;
   endfunction

   function automatic bit f_legal(input logic mw, input logic [1:0] rs, input logic [2:0] f3,
                                  input logic [31:0] a);
      return f_memop(mw, rs) && !f_fault(mw, rs, f3, a);
   endfunction

   function automatic logic [3:0] f_be(input logic mw, input logic [2:0] f3, input logic [31:0] a);
      int n;
      if (!mw) return 4'hF;
      n = 1 << (f3 % 4);
      return 4'(((1 << n) - 1) << (a % 4));
   endfunction

   function automatic logic [31:0] f_wdata(input logic [2:0] f3, input logic [31:0] wd);
      case (f3 % 4)
         0:       return {24'd0, wd[7:0]} * 32'h01010101;
         1:       return {16'd0, wd[15:0]} * 32'h00010001;
         default: return wd;
      endcase
   endfunction

   function automatic logic [31:0] f_load(input logic [2:0] f3, input logic [31:0] a,
                                          input logic [31:0] w);
      int size;
      int bits;
      logic [31:0] v;
      size = f3 % 4;
      if (size == 2) return w;
      bits = 8 << size;
      v = (w >> ((a % 4) * 8)) & ((32'd1 << bits) - 1);
      if (f3 < 4 && v >= (32'd1 << (bits - 1))) v = v - (32'd1 << bits);
      return v;
   endfunction

   logic        m_rw, m_fault;
   logic [1:0]  m_rs;
   logic [4:0]  m_rd;
   logic [31:0] m_pc, m_alu, m_rdata, m_imm;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_rw <= 0; m_fault <= 0; m_rs <= 0; m_rd <= 0;
         m_pc <= 0; m_alu <= 0; m_rdata <= 0; m_imm <= 0;
      end else if (f_legal(MemWriteD, ResultSrcD, Funct3D, ALUResultD) && !dmem_ready) begin
         m_rw <= 0; m_fault <= 0;
      end else begin
         m_fault <= f_fault(MemWriteD, ResultSrcD, Funct3D, ALUResultD);
         m_rw    <= RegWriteD && !MemWriteD && !f_fault(MemWriteD, ResultSrcD, Funct3D, ALUResultD);
         m_rs    <= ResultSrcD;
         m_rd    <= RdD;
         m_pc    <= PCPlus4D;
         m_alu   <= ALUResultD;
         m_imm   <= UpperImmExtD;
         m_rdata <= (f_legal(MemWriteD, ResultSrcD, Funct3D, ALUResultD) && ResultSrcD == 2'd1)
                    ? f_load(Funct3D, ALUResultD, dmem_rdata) : 32'd0;
      end
   end

   always @(negedge clk) begin
      bit lg;
      if (cmp_en) begin
         lg = !rst && f_legal(MemWriteD, ResultSrcD, Funct3D, ALUResultD);
         chk("dmem_req", dmem_req, lg);
         chk("StallM", StallM, lg && !dmem_ready);
         chk("fwd_alu", ForwardALUResultDH, ALUResultD);
         if (lg) begin
            chk("dmem_addr", dmem_addr, ALUResultD & ~32'd3);
            chk("dmem_we", dmem_we, MemWriteD);
            chk("dmem_be", dmem_be, f_be(MemWriteD, Funct3D, ALUResultD));
            if (MemWriteD) chk("dmem_wdata", dmem_wdata, f_wdata(Funct3D, MemWriteDataD));
         end
         chk("RegWriteE", RegWriteE, m_rw);
         chk("MemFaultE", MemFaultE, m_fault);
         chk("ResultSrcE", ResultSrcE, m_rs);
         chk("RdE", RdE, m_rd);
         chk("PCPlus4E", PCPlus4E, m_pc);
         chk("ALUResultE", ALUResultE, m_alu);
         chk("ReadDataE", ReadDataE, m_rdata);
         chk("UpperImmExtE", UpperImmExtE, m_imm);
      end
   end

   // ---------------- stimulus ----------------
   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic set_op(input logic rw, input logic mw, input logic [1:0] rs, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] wd, input logic [4:0] rd);
      RegWriteD = rw; MemWriteD = mw; ResultSrcD = rs; Funct3D = f3;
      ALUResultD = a; MemWriteDataD = wd; RdD = rd;
      PCPlus4D = a + 32'd4; UpperImmExtD = 32'h000AB000;
   endtask

   task automatic rand_op();
      int kind;
      int r;
      kind = $urandom_range(0, 2);
      RegWriteD = 1'($urandom_range(0, 1));
      PCPlus4D = $urandom; ALUResultD = $urandom; MemWriteDataD = $urandom;
      UpperImmExtD = $urandom; RdD = 5'($urandom_range(0, 31));
      Funct3D = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 1) == 1) ALUResultD[1:0] = 2'b00;
      case (kind)
         0: begin
            MemWriteD = 0;
            r = $urandom_range(0, 2);
            ResultSrcD = (r == 0) ? 2'd0 : 2'(r + 1);
         end
         1: begin MemWriteD = 0; ResultSrcD = 2'd1; end
         default: begin
            MemWriteD = 1; ResultSrcD = 2'd0;
            if ($urandom_range(0, 1) == 1) Funct3D = 3'($urandom_range(0, 2));
         end
      endcase
   endtask

   initial begin
      rst = 1'b1;
      set_op(1, 0, 2'd1, 3'b010, 32'h0, 32'h0, 5'd1);
      dmem_ready = 1'b0; dmem_rdata = 32'h0;
      tick();
      cmp_en = 1'b1;
      tick();
      chk("rst_dmem_req", dmem_req, 1'b0);
      chk("rst_StallM", StallM, 1'b0);
      chk("rst_RegWriteE", RegWriteE, 1'b0);
      chk("rst_MemFaultE", MemFaultE, 1'b0);
      chk("rst_ALUResultE", ALUResultE, 32'h0);

      // pass-through ADD
      rst = 1'b0;
      set_op(1, 0, 2'd0, 3'b000, 32'h1234, 32'h0, 5'd5);
      #1 chk("pt_req", dmem_req, 1'b0);
      tick();
      chk("pt_RegWriteE", RegWriteE, 1'b1);
      chk("pt_ALUResultE", ALUResultE, 32'h1234);
      chk("pt_RdE", RdE, 5'd5);

      // SB at byte 3, same-cycle ready
      set_op(1, 1, 2'd0, 3'b000, 32'h103, 32'h000000A5, 5'd6);
      dmem_ready = 1'b1;
      #1;
      chk("sb_be", dmem_be, 4'b1000);
      chk("sb_wdata", dmem_wdata, 32'hA5A5A5A5);
      chk("sb_stall", StallM, 1'b0);
      tick();
      chk("sb_RegWriteE", RegWriteE, 1'b0);

      // SH upper half, same-cycle completion
      set_op(1, 1, 2'd0, 3'b001, 32'h2, 32'h0000BEEF, 5'd6);
      #1;
      chk("sh_be", dmem_be, 4'b1100);
      chk("sh_wdata", dmem_wdata, 32'hBEEFBEEF);
      chk("sh_req", dmem_req, 1'b1);
      chk("sh_stall", StallM, 1'b0);
      tick();
      chk("sh_MemFaultE", MemFaultE, 1'b0);

      // LB then LBU with three wait cycles each
      for (int pass = 0; pass < 2; pass++) begin
         set_op(1, 0, 2'd1, (pass == 0) ? 3'b000 : 3'b100, 32'h202, 32'h0, 5'd7);
         dmem_ready = 1'b0; dmem_rdata = 32'h00800000;
         for (int k = 0; k < 3; k++) begin
            #1 chk("lb_stall", StallM, 1'b1);
            tick();
            chk("lb_bubble", RegWriteE, 1'b0);
         end
         dmem_ready = 1'b1;
         #1 chk("lb_nostall", StallM, 1'b0);
         tick();
         chk("lb_ReadDataE", ReadDataE, (pass == 0) ? 32'hFFFFFF80 : 32'h00000080);
         chk("lb_RegWriteE", RegWriteE, 1'b1);
      end

      // misaligned LW faults
      set_op(1, 0, 2'd1, 3'b010, 32'h302, 32'h0, 5'd8);
      dmem_ready = 1'b0;
      #1;
      chk("lw_req", dmem_req, 1'b0);
      chk("lw_stall", StallM, 1'b0);
      tick();
      chk("lw_MemFaultE", MemFaultE, 1'b1);
      chk("lw_RegWriteE", RegWriteE, 1'b0);
      set_op(0, 0, 2'd0, 3'b000, 32'h40, 32'h0, 5'd0);
      tick();
      chk("lw_fault_clear", MemFaultE, 1'b0);

      // reset during WAIT, late ready afterwards
      set_op(1, 0, 2'd1, 3'b001, 32'h10, 32'h0, 5'd9);
      dmem_ready = 1'b0; dmem_rdata = 32'h12345678;
      #1 chk("lh_stall", StallM, 1'b1);
      tick();
      #1 rst = 1'b1;
      #1;
      chk("wrst_req", dmem_req, 1'b0);
      chk("wrst_stall", StallM, 1'b0);
      chk("wrst_PCPlus4E", PCPlus4E, 32'h0);
      chk("wrst_ALUResultE", ALUResultE, 32'h0);
      chk("wrst_RdE", RdE, 5'd0);
      set_op(1, 0, 2'd0, 3'b000, 32'h55, 32'h0, 5'd3);
      dmem_ready = 1'b1;
      #2 rst = 1'b0;
      tick();
      chk("post_RegWriteE", RegWriteE, 1'b1);
      chk("post_ALUResultE", ALUResultE, 32'h55);
      chk("post_ReadDataE", ReadDataE, 32'h0);

      // randomized traffic; upstream holds inputs while stalled
      for (int i = 0; i < 800; i++) begin
         bit st;
         st = f_legal(MemWriteD, ResultSrcD, Funct3D, ALUResultD) && !dmem_ready;
         tick();
         if (!st) rand_op();
         dmem_ready = ($urandom_range(0, 99) < 55);
         dmem_rdata = $urandom;
      end

      tick();
      cmp_en = 1'b0;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
